ttlc_icu: RTL and testbench

TTLC_ICU -- requirements
Module: ttlc_icu

---
 rtl/ttlc_pkg.sv | 40 ++++
 rtl/ttlc_icu_if.sv | 28 ++
 rtl/ttlc_icu_logic.sv | 40 ++++
 rtl/ttlc_icu.sv | 147 ++++++++++++++
 tb/tb_ttlc_icu.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttlc_pkg.sv
// ttlc_pkg: shared definitions for the TTLC one-bit instruction control unit.
// Holds the 4-bit opcode map, the sequencer state encoding, instruction field
// widths and a small helper that packs an instruction word (used by the
// assembler-style testbench to build programs).
package ttlc_pkg;

    localparam int IR_W  = 12;   // instruction word width
    localparam int IO_AW = 8;    // I/O bit-address width

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    // Pack opcode and I/O bit address into one program word.
    function automatic logic [IR_W-1:0] mk_instr(opcode_e op, logic [IO_AW-1:0] addr);
        return {op, addr};
    endfunction

endpackage

// File: rtl/ttlc_icu_if.sv
// ttlc_icu_if: program-fetch handshake and I/O bit-map bus of the ICU.
//   prog_req/prog_addr   ICU -> program memory, request held until prog_valid
//   prog_valid/prog_data program memory -> ICU, accepts the request
//   io_addr/io_write/io_wdata  ICU -> I/O map, single-cycle bit write
//   io_rdata             I/O map -> ICU, combinational read of bit at io_addr
// master = ICU side, slave = program memory / I/O map side.
interface ttlc_icu_if #(
    parameter int PC_W = 8
);
    logic            prog_req;
    logic [PC_W-1:0] prog_addr;
    logic            prog_valid;
    logic [11:0]     prog_data;
    logic [7:0]      io_addr;
    logic            io_write;
    logic            io_wdata;
    logic            io_rdata;

    modport master (
        output prog_req, prog_addr, io_addr, io_write, io_wdata,
        input  prog_valid, prog_data, io_rdata
    );

    modport slave (
        input  prog_req, prog_addr, io_addr, io_write, io_wdata,
        output prog_valid, prog_data, io_rdata
    );
endinterface

// File: rtl/ttlc_icu_logic.sv
// ttlc_icu_logic: combinational next-value unit for the result register (RR)
// and the input/output enable registers (IEN/OEN).
//   opcode      current instruction opcode
//   d           operand (I/O bit already masked by IEN)
//   rr/ien/oen  current register values
//   rr_d/ien_d/oen_d  values to load if the instruction executes this cycle
module ttlc_icu_logic
    import ttlc_pkg::*;
(
    input  opcode_e opcode,
    input  logic    d,
    input  logic    rr,
    input  logic    ien,
    input  logic    oen,
    output logic    rr_d,
    output logic    ien_d,
    output logic    oen_d
);

    always_comb begin
        rr_d  = rr;
        ien_d = ien;
        oen_d = oen;
        case (opcode)
            OP_LD:   rr_d  = d;
            OP_LDC:  rr_d  = ~d;
            OP_AND:  rr_d  = rr & d;
            OP_ANDC: rr_d  = rr & ~d;
            OP_OR:   rr_d  = rr | d;
            OP_ORC:  rr_d  = rr | ~d;
            OP_XNOR: rr_d  = ~(rr ^ d);
            // The enables load the masked operand, so once IEN is cleared
            // only reset can re-open the input path.
            OP_IEN:  ien_d = d;
            OP_OEN:  oen_d = d;
            default: ;
        endcase
    end

endmodule

// File: rtl/ttlc_icu.sv
// ttlc_icu: MC14500-style one-bit industrial control unit.
// Sequencer IDLE -> FETCH -> EXEC; one instruction per two cycles when the
// program memory answers in the first FETCH cycle.
//   clk, rst_n  clock, asynchronous active-low reset
//   run         fetch/execute enable, sampled at instruction boundaries
//   bus         program fetch + I/O bit bus (master modport)
//   rr_value    current result register
//   flag_o/flag_f, jmp_o/rtn_o  one-cycle pulses during EXEC of the
//               respective instruction
module ttlc_icu
    import ttlc_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    ttlc_icu_if.master         bus,
    output logic               rr_value,
    output logic               flag_o,
    output logic               flag_f,
    output logic               jmp_o,
    output logic               rtn_o
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            rr_q, rr_d;
    logic            ien_q, ien_d;
    logic            oen_q, oen_d;
    logic [PC_W-1:0] ret_q, ret_d;
    logic            ret_vld_q, ret_vld_d;

    opcode_e         opcode;
    logic            in_exec;
    logic            operand;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jmp_target;
    logic            alu_rr, alu_ien, alu_oen;

    assign opcode     = opcode_e'(ir_q[11:8]);
    assign in_exec    = (state_q == ST_EXEC);
    assign operand    = bus.io_rdata & ien_q;
    assign pc_inc     = pc_q + PC_ONE;
    // Zero-extends or truncates the 8-bit address field to the PC width.
    assign jmp_target = PC_W'(ir_q[7:0]);

    ttlc_icu_logic u_logic (
        .opcode (opcode),
        .d      (operand),
        .rr     (rr_q),
        .ien    (ien_q),
        .oen    (oen_q),
        .rr_d   (alu_rr),
        .ien_d  (alu_ien),
        .oen_d  (alu_oen)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rr_d      = rr_q;
        ien_d     = ien_q;
        oen_d     = oen_q;
        ret_d     = ret_q;
        ret_vld_d = ret_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // run is not looked at here: an issued fetch always completes.
                if (bus.prog_valid) begin
                    ir_d    = bus.prog_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = run ? ST_FETCH : ST_IDLE;
                rr_d    = alu_rr;
                ien_d   = alu_ien;
                oen_d   = alu_oen;
                pc_d    = pc_inc;
                case (opcode)
                    OP_JMP: begin
                        pc_d      = jmp_target;
                        ret_d     = pc_inc;
                        ret_vld_d = 1'b1;
                    end
                    OP_RTN: begin
                        // Return skips the instruction after the call site.
                        if (ret_vld_q) pc_d = ret_q + PC_ONE;
                        ret_vld_d = 1'b0;
                    end
                    OP_SKZ: begin
                        if (!rr_q) pc_d = pc_q + PC_TWO;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RST_PC;
            ir_q      <= '0;
            rr_q      <= 1'b0;
            ien_q     <= 1'b1;
            oen_q     <= 1'b1;
            ret_q     <= '0;
            ret_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            rr_q      <= rr_d;
            ien_q     <= ien_d;
            oen_q     <= oen_d;
            ret_q     <= ret_d;
            ret_vld_q <= ret_vld_d;
        end
    end

    // All strobes decode registered state, so reset forces them low at once.
    // io_addr follows IR, which only changes on entry to EXEC and so holds
    // its last value outside EXEC.
    assign bus.prog_req  = (state_q == ST_FETCH);
    assign bus.prog_addr = pc_q;
    assign bus.io_addr   = ir_q[7:0];
    assign bus.io_write  = in_exec && oen_q && (opcode == OP_STO || opcode == OP_STOC);
    assign bus.io_wdata  = (opcode == OP_STOC) ? ~rr_q : rr_q;
    assign rr_value      = rr_q;
    assign flag_o        = in_exec && (opcode == OP_NOPO);
    assign flag_f        = in_exec && (opcode == OP_NOPF);
    assign jmp_o         = in_exec && (opcode == OP_JMP);
    assign rtn_o         = in_exec && (opcode == OP_RTN);

endmodule

// File: tb/tb_ttlc_icu.sv
// tb_ttlc_icu: scoreboard bench for ttlc_icu. Programs are assembled with
// mk_instr into a program-memory model; expected fetch addresses, I/O writes
// and pulses are queued per segment and a negedge monitor compares them as
// the DUT presents them.
module tb_ttlc_icu;
    import ttlc_pkg::*;

    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic rr_value, flag_o, flag_f, jmp_o, rtn_o;

    ttlc_icu_if #(.PC_W(PC_W)) bus ();

    ttlc_icu #(.PC_W(PC_W), .RST_PC(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .bus      (bus),
        .rr_value (rr_value),
        .flag_o   (flag_o),
        .flag_f   (flag_f),
        .jmp_o    (jmp_o),
        .rtn_o    (rtn_o)
    );

    always #5 clk = ~clk;

    logic [11:0] pmem [256];
    logic        io_mem [256];
    int          stall_left = 0;
    bit          spurious = 1'b0;

    assign bus.io_rdata = io_mem[bus.io_addr];

    typedef struct {
        logic [7:0] addr;
        logic       data;
    } wr_t;

    wr_t             wq[$];
    logic [PC_W-1:0] fq[$];
    logic [3:0]      pq[$];   // {flag_o, flag_f, jmp_o, rtn_o}

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] P_FO  = 4'b1000;
    localparam logic [3:0] P_FF  = 4'b0100;
    localparam logic [3:0] P_JMP = 4'b0010;
    localparam logic [3:0] P_RTN = 4'b0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    // Program memory responder: answers a pending request unless stalling.
    initial begin
        bus.prog_valid = 1'b0;
        bus.prog_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.prog_data = pmem[bus.prog_addr];
            if (spurious) begin
                bus.prog_valid = 1'b1;
            end else if (bus.prog_req && stall_left > 0) begin
                bus.prog_valid = 1'b0;
                stall_left--;
            end else begin
                bus.prog_valid = bus.prog_req;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.prog_req && bus.prog_valid) begin
                    if (fq.size() == 0) chk("unexpected_fetch", 32'(bus.prog_addr), 32'hFFFF);
                    else begin
                        logic [PC_W-1:0] ea;
                        ea = fq.pop_front();
                        chk("fetch_addr", 32'(bus.prog_addr), 32'(ea));
                        $display("fetch addr=%02h", bus.prog_addr);
                    end
                end else if (bus.prog_req && fq.size() != 0) begin
                    chk("stall_addr", 32'(bus.prog_addr), 32'(fq[0]));
                end
                if (bus.io_write) begin
                    if (wq.size() == 0) chk("unexpected_write", 32'(bus.io_addr), 32'hFFFF);
                    else begin
                        wr_t w;
                        w = wq.pop_front();
                        chk("wr_addr", 32'(bus.io_addr), 32'(w.addr));
                        chk("wr_data", 32'(bus.io_wdata), 32'(w.data));
                        $display("write addr=%02h data=%0b", bus.io_addr, bus.io_wdata);
                    end
                end
                if ({flag_o, flag_f, jmp_o, rtn_o} != 4'b0000) begin
                    if (pq.size() == 0) chk("unexpected_pulse", 32'({flag_o, flag_f, jmp_o, rtn_o}), 32'h0);
                    else begin
                        logic [3:0] ep;
                        ep = pq.pop_front();
                        chk("pulse", 32'({flag_o, flag_f, jmp_o, rtn_o}), 32'(ep));
                        $display("pulse fo/ff/jmp/rtn=%04b", {flag_o, flag_f, jmp_o, rtn_o});
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prog_req"}, 32'(bus.prog_req), 32'h0);
        chk({tag, "_prog_addr"}, 32'(bus.prog_addr), 32'h0);
        chk({tag, "_io_addr"}, 32'(bus.io_addr), 32'h0);
        chk({tag, "_io_write"}, 32'(bus.io_write), 32'h0);
        chk({tag, "_rr"}, 32'(rr_value), 32'h0);
        chk({tag, "_pulses"}, 32'({flag_o, flag_f, jmp_o, rtn_o}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until every queued fetch has been accepted (or drops run early,
    // mid-fetch, when drop_after > 0), then checks the stopped state.
    task automatic run_seg(input string tag, input logic [7:0] exp_pc,
                           input logic exp_rr, input int drop_after);
        int n;
        n = 0;
        run = 1'b1;
        while (fq.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
            if (drop_after > 0 && n == drop_after) run = 1'b0;
        end
        chk({tag, "_fetch_timeout"}, 32'(n < 300), 32'h1);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_idle_req"}, 32'(bus.prog_req), 32'h0);
        chk({tag, "_next_pc"}, 32'(bus.prog_addr), 32'(exp_pc));
        chk({tag, "_rr"}, 32'(rr_value), 32'(exp_rr));
        chk({tag, "_writes_left"}, 32'(wq.size()), 32'h0);
        chk({tag, "_pulses_left"}, 32'(pq.size()), 32'h0);
        $display("segment %s done pc=%02h rr=%0b", tag, bus.prog_addr, rr_value);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            pmem[i]   = 12'h000;
            io_mem[i] = 1'b0;
        end
        io_mem[8'h30] = 1'b1;
        io_mem[8'h31] = 1'b1;

        do_reset();

        // Load and store a set bit.
        pmem[0] = mk_instr(OP_LD,  8'h30);
        pmem[1] = mk_instr(OP_STO, 8'h00);
        fq.push_back(8'h00); fq.push_back(8'h01);
        exp_wr(8'h00, 1'b1);
        run_seg("ld_sto", 8'h02, 1'b1, 0);

        // OEN gating of stores.
        pmem[2] = mk_instr(OP_LDC,  8'h31);
        pmem[3] = mk_instr(OP_OEN,  8'h32);
        pmem[4] = mk_instr(OP_STO,  8'h05);
        pmem[5] = mk_instr(OP_LD,   8'h31);
        pmem[6] = mk_instr(OP_OEN,  8'h31);
        pmem[7] = mk_instr(OP_STOC, 8'h05);
        for (int a = 2; a <= 7; a++) fq.push_back(PC_W'(a));
        exp_wr(8'h05, 1'b0);
        run_seg("oen", 8'h08, 1'b1, 0);

        // Logic ops, then IEN masking of LD and XNOR.
        pmem[8]  = mk_instr(OP_AND,  8'h40);
        pmem[9]  = mk_instr(OP_ORC,  8'h40);
        pmem[10] = mk_instr(OP_ANDC, 8'h31);
        pmem[11] = mk_instr(OP_OR,   8'h31);
        pmem[12] = mk_instr(OP_XNOR, 8'h40);
        pmem[13] = mk_instr(OP_STOC, 8'h06);
        pmem[14] = mk_instr(OP_XNOR, 8'h31);
        pmem[15] = mk_instr(OP_STO,  8'h07);
        pmem[16] = mk_instr(OP_LDC,  8'h40);
        pmem[17] = mk_instr(OP_IEN,  8'h40);
        pmem[18] = mk_instr(OP_LD,   8'h31);
        pmem[19] = mk_instr(OP_STOC, 8'h08);
        pmem[20] = mk_instr(OP_XNOR, 8'h31);
        pmem[21] = mk_instr(OP_STO,  8'h09);
        for (int a = 8; a <= 21; a++) fq.push_back(PC_W'(a));
        exp_wr(8'h06, 1'b1);
        exp_wr(8'h07, 1'b0);
        exp_wr(8'h08, 1'b1);
        exp_wr(8'h09, 1'b1);
        run_seg("alu_ien", 8'h16, 1'b1, 0);

        // Jump / return / unmatched return / flags.
        do_reset();
        pmem[8'h00] = mk_instr(OP_JMP,  8'h10);
        pmem[8'h10] = mk_instr(OP_JMP,  8'h40);
        pmem[8'h40] = mk_instr(OP_RTN,  8'h00);
        pmem[8'h12] = mk_instr(OP_RTN,  8'h00);
        pmem[8'h13] = mk_instr(OP_NOPO, 8'h00);
        pmem[8'h14] = mk_instr(OP_NOPF, 8'h00);
        fq.push_back(8'h00); fq.push_back(8'h10); fq.push_back(8'h40);
        fq.push_back(8'h12); fq.push_back(8'h13); fq.push_back(8'h14);
        pq.push_back(P_JMP); pq.push_back(P_JMP); pq.push_back(P_RTN);
        pq.push_back(P_RTN); pq.push_back(P_FO);  pq.push_back(P_FF);
        run_seg("jmp_rtn", 8'h15, 1'b0, 0);

        // SKZ at the top of program space, RR=0 then RR=1.
        pmem[8'h15] = mk_instr(OP_JMP,  8'hFF);
        pmem[8'hFF] = mk_instr(OP_SKZ,  8'h00);
        pmem[8'h01] = mk_instr(OP_LDC,  8'h40);
        pmem[8'h02] = mk_instr(OP_JMP,  8'hFF);
        pmem[8'h00] = mk_instr(OP_NOPF, 8'h00);
        fq.push_back(8'h15); fq.push_back(8'hFF); fq.push_back(8'h01);
        fq.push_back(8'h02); fq.push_back(8'hFF); fq.push_back(8'h00);
        pq.push_back(P_JMP); pq.push_back(P_JMP); pq.push_back(P_FF);
        run_seg("skz_wrap", 8'h01, 1'b1, 0);

        // 5-cycle fetch stall with run dropped mid-fetch.
        pmem[8'h01] = mk_instr(OP_STO, 8'h0A);
        pmem[8'h02] = mk_instr(OP_STO, 8'h0B);
        fq.push_back(8'h01);
        exp_wr(8'h0A, 1'b1);
        stall_left = 5;
        run_seg("stall_drop", 8'h02, 1'b1, 3);

        // prog_valid while idle must be ignored.
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("spurious_req", 32'(bus.prog_req), 32'h0);
        chk("spurious_pc", 32'(bus.prog_addr), 32'h02);
        spurious = 1'b0;
        @(negedge clk);

        // Reset during the EXEC of a store: no write, PC back to reset value.
        fq.push_back(8'h02);
        run = 1'b1;
        begin
            int n;
            n = 0;
            while (fq.size() != 0 && n < 100) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("rst_exec_timeout", 32'(n < 100), 32'h1);
        end
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check_reset_outputs("rst_exec");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fq.push_back(8'h00);
        pq.push_back(P_FF);
        run_seg("post_rst", 8'h01, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
